// File: rtl/input_network_decoder.sv
// Serial inverse of the arbiter-PUF challenge input network: rebuilds the raw
// challenge d from a transformed vector c, one bit per clock, valid/ready on both sides.
module input_network_decoder #(
   parameter int unsigned N_CB  = 32,
   parameter int unsigned IDX_W = $clog2(N_CB)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CB-1:0] c_in,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [N_CB-1:0] d_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy
);

   localparam int unsigned      HALF     = N_CB / 2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CB - 1);
   localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(HALF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [N_CB-1:0]   c_q, c_d;
   logic [N_CB-1:0]   d_q, d_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [IDX_W-1:0]  p_pos_c;
   logic [IDX_W-1:0]  idx_prev_c;
   logic              p_bit_c;

   // Locate the parity bit for the current index: odd j packs low, even j packs above c[N/2].
   always_comb begin
      p_pos_c    = '0;
      idx_prev_c = idx_q - IDX_W'(1);
      if (idx_q[0]) begin
         p_pos_c = {1'b0, idx_q[IDX_W-1:1]};
      end else begin
         p_pos_c = IDX_HALF + {1'b0, idx_q[IDX_W-1:1]};
      end
      p_bit_c = c_q[p_pos_c];
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      idx_d   = idx_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               c_d     = c_in;
               d_d     = '0;
               d_d[0]  = c_in[HALF];
               idx_d   = IDX_W'(1);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            d_d[idx_q] = d_q[idx_prev_c] ^ p_bit_c;
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered from the upcoming state.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         c_q         <= '0;
         d_q         <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign d_out     = d_q;

endmodule
